irq_dispatch: RTL and testbench

Interrupt dispatcher that sits directly upstream of the core pipeline's interrupt input. It holds the 64-entry IRQ configuration table, which the core programs through its IRQ config-table outputs. It latches rising edges on 64 device IRQ lines as pending requests and offers the highest-priority eligible request to the core over a valid/ack handshake. The offered entry is held stable until the core acknowledges it.

---
 rtl/irq_pkg.sv | 21 ++
 rtl/irq_priority_select.sv | 27 ++
 rtl/irq_dispatch.sv | 119 +++++++++++
 tb/tb_irq_dispatch.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt dispatcher.
package irq_pkg;

  localparam int unsigned IrqNum     = 64;
  localparam int unsigned EntryWidth = 6;

  typedef struct packed {
    logic       valid;
    logic       mask;
    logic [1:0] level;
  } irq_entry_t;

  typedef enum logic [0:0] {
    IRQ_IDLE,
    IRQ_OFFER
  } irq_state_t;

  // Out of reset every source is disabled, masked and at the lowest level.
  localparam irq_entry_t EntryReset = '{valid: 1'b0, mask: 1'b1, level: 2'b00};

endpackage

// File: rtl/irq_priority_select.sv
// Combinational winner pick: highest level first, lowest index breaks ties.
module irq_priority_select
  import irq_pkg::*;
(
  input  logic [IrqNum-1:0]     eligible,
  input  logic [2*IrqNum-1:0]   levels,
  output logic                  found,
  output logic [EntryWidth-1:0] num
);

  logic [1:0] bestLevel;

  // Ascending scan; strictly-greater replacement keeps the lowest index on ties.
  always_comb begin
    found     = 1'b0;
    num       = '0;
    bestLevel = 2'b00;
    for (int k = 0; k < IrqNum; k++) begin
      if (eligible[k] && (!found || (levels[2*k +: 2] > bestLevel))) begin
        found     = 1'b1;
        num       = EntryWidth'(k);
        bestLevel = levels[2*k +: 2];
      end
    end
  end

endmodule

// File: rtl/irq_dispatch.sv
// Interrupt dispatcher: config table, edge latching, priority offer to the core.
module irq_dispatch
  import irq_pkg::*;
(
  input  logic                  iCLOCK,
  input  logic                  iRESET_SYNC,
  input  logic                  iCONFIG_REQ,
  input  logic [EntryWidth-1:0] iCONFIG_ENTRY,
  input  logic                  iCONFIG_FLAG_MASK,
  input  logic                  iCONFIG_FLAG_VALID,
  input  logic [1:0]            iCONFIG_FLAG_LEVEL,
  input  logic [IrqNum-1:0]     iIRQ,
  output logic                  oINTERRUPT_VALID,
  output logic [EntryWidth-1:0] oINTERRUPT_NUM,
  input  logic                  iINTERRUPT_ACK
);

  irq_entry_t                tableQ [IrqNum];
  logic [IrqNum-1:0]         pendingQ, pendingD, prevQ;
  logic [IrqNum-1:0]         validVec, maskVec, eligible, newEdge;
  logic [2*IrqNum-1:0]       levelVec;
  irq_state_t                stateQ, stateD;
  logic                      validQ, validD;
  logic [EntryWidth-1:0]     numQ, numD, winnerNum;
  logic                      found;

  // Flatten the table into per-field vectors for the selector and edge logic.
  always_comb begin
    validVec = '0;
    maskVec  = '0;
    levelVec = '0;
    for (int k = 0; k < IrqNum; k++) begin
      validVec[k]         = tableQ[k].valid;
      maskVec[k]          = tableQ[k].mask;
      levelVec[2*k +: 2]  = tableQ[k].level;
    end
  end

  assign newEdge  = iIRQ & ~prevQ & validVec;
  assign eligible = pendingQ & validVec & ~maskVec;

  irq_priority_select uSelect (
    .eligible (eligible),
    .levels   (levelVec),
    .found    (found),
    .num      (winnerNum)
  );

  // Pending update: ack clear, then new edges (set beats ack), then invalidation clear.
  always_comb begin
    pendingD = pendingQ;
    if ((stateQ == IRQ_OFFER) && iINTERRUPT_ACK) begin
      pendingD[numQ] = 1'b0;
    end
    pendingD = pendingD | newEdge;
    if (iCONFIG_REQ && !iCONFIG_FLAG_VALID) begin
      pendingD[iCONFIG_ENTRY] = 1'b0;
    end
  end

  // Offer FSM: an offer, once registered, is held until acknowledged.
  always_comb begin
    stateD = stateQ;
    validD = validQ;
    numD   = numQ;
    unique case (stateQ)
      IRQ_IDLE: begin
        if (found) begin
          stateD = IRQ_OFFER;
          validD = 1'b1;
          numD   = winnerNum;
        end
      end
      IRQ_OFFER: begin
        if (iINTERRUPT_ACK) begin
          stateD = IRQ_IDLE;
          validD = 1'b0;
        end
      end
      default: begin
        stateD = IRQ_IDLE;
        validD = 1'b0;
      end
    endcase
  end

  // Configuration table writes.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      for (int k = 0; k < IrqNum; k++) begin
        tableQ[k] <= EntryReset;
      end
    end else if (iCONFIG_REQ) begin
      tableQ[iCONFIG_ENTRY] <= '{valid: iCONFIG_FLAG_VALID, mask: iCONFIG_FLAG_MASK,
                                 level: iCONFIG_FLAG_LEVEL};
    end
  end

  // Pending, edge history and FSM registers.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      pendingQ <= '0;
      prevQ    <= '0;
      stateQ   <= IRQ_IDLE;
      validQ   <= 1'b0;
      numQ     <= '0;
    end else begin
      pendingQ <= pendingD;
      prevQ    <= iIRQ;
      stateQ   <= stateD;
      validQ   <= validD;
      numQ     <= numD;
    end
  end

  assign oINTERRUPT_VALID = validQ;
  assign oINTERRUPT_NUM   = numQ;

endmodule

// File: tb/tb_irq_dispatch.sv
// Scoreboard bench for irq_dispatch against a cycle-level reference model.
module tb_irq_dispatch;

  logic        iCLOCK = 1'b0;
  logic        rst = 1'b1;
  logic        cfgReq = 1'b0;
  logic [5:0]  cfgEnt = '0;
  logic        cfgM = 1'b1;
  logic        cfgV = 1'b0;
  logic [1:0]  cfgL = '0;
  logic [63:0] irq = '0;
  logic        ack = 1'b0;
  logic        outValid;
  logic [5:0]  outNum;

  irq_dispatch dut (
    .iCLOCK             (iCLOCK),
    .iRESET_SYNC        (rst),
    .iCONFIG_REQ        (cfgReq),
    .iCONFIG_ENTRY      (cfgEnt),
    .iCONFIG_FLAG_MASK  (cfgM),
    .iCONFIG_FLAG_VALID (cfgV),
    .iCONFIG_FLAG_LEVEL (cfgL),
    .iIRQ               (irq),
    .oINTERRUPT_VALID   (outValid),
    .oINTERRUPT_NUM     (outNum),
    .iINTERRUPT_ACK     (ack)
  );

  always #5 iCLOCK = ~iCLOCK;

  typedef struct {
    int num;
    int cyc;
  } exp_t;

  exp_t expQ[$];
  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;
  bit   started = 0;
  bit   lastV = 0;

  // Reference model state.
  bit mV[64];
  bit mM[64];
  int mL[64];
  bit mPend[64];
  bit mPrev[64];
  bit mOffer = 0;
  int mNum = 0;

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic modelEdge();
    int win;
    bit fnd;
    bit nxt[64];
    cycle++;
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        mV[i] = 0; mM[i] = 1; mL[i] = 0; mPend[i] = 0; mPrev[i] = 0;
      end
      mOffer = 0;
      mNum   = 0;
      return;
    end
    fnd = 0;
    win = 0;
    for (int lv = 3; lv >= 0; lv--) begin
      for (int i = 0; i < 64; i++) begin
        if (!fnd && mPend[i] && mV[i] && !mM[i] && mL[i] == lv) begin
          fnd = 1;
          win = i;
        end
      end
    end
    nxt = mPend;
    if (mOffer && ack) nxt[mNum] = 0;
    for (int i = 0; i < 64; i++) begin
      if (irq[i] && !mPrev[i] && mV[i]) nxt[i] = 1;
    end
    if (cfgReq && !cfgV) nxt[cfgEnt] = 0;
    if (!mOffer) begin
      if (fnd) begin
        mOffer = 1;
        mNum   = win;
        expQ.push_back('{win, cycle});
      end
    end else if (ack) begin
      mOffer = 0;
    end
    if (cfgReq) begin
      mV[cfgEnt] = cfgV;
      mM[cfgEnt] = cfgM;
      mL[cfgEnt] = int'(cfgL);
    end
    for (int i = 0; i < 64; i++) mPrev[i] = irq[i];
    mPend = nxt;
  endtask

  task automatic tick();
    @(posedge iCLOCK);
    modelEdge();
    #1;
  endtask

  task automatic cfg(input int e, input bit v, input bit m, input int l);
    cfgReq = 1; cfgEnt = 6'(e); cfgV = v; cfgM = m; cfgL = 2'(l);
    tick();
    cfgReq = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic ackPulse();
    ack = 1;
    tick();
    ack = 0;
  endtask

  // Clear leftover requests and offers between directed scenarios.
  task automatic drain();
    irq = '0;
    repeat (8) begin
      ackPulse();
      tick();
    end
  endtask

  // Monitor: checks outputs every cycle and pops an expectation on each new offer.
  always @(negedge iCLOCK) begin
    if (started) begin
      tests++;
      if (outValid !== mOffer) begin
        fails++;
        $display("FAIL valid cyc=%0d got=%0b want=%0b", cycle, outValid, mOffer);
      end
      tests++;
      if (outNum !== 6'(mNum)) begin
        fails++;
        $display("FAIL num cyc=%0d got=%0d want=%0d", cycle, outNum, mNum);
      end
      if (outValid === 1'b1 && !lastV) begin
        tests++;
        if (expQ.size() == 0) begin
          fails++;
          $display("FAIL offer cyc=%0d got=%0d want=none", cycle, outNum);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          if (outNum !== 6'(e.num) || cycle != e.cyc) begin
            fails++;
            $display("FAIL offer got num=%0d cyc=%0d want num=%0d cyc=%0d",
                     outNum, cycle, e.num, e.cyc);
          end
        end
      end
      lastV = (outValid === 1'b1);
    end
  end

  initial begin
    rst = 1;
    tick();
    started = 1;
    tick();
    rst = 0;
    tick();

    // Single source, basic offer and ack.
    cfg(5, 1, 0, 1);
    irq[5] = 1;
    idle(3);
    ackPulse();
    idle(2);
    drain();

    // Level priority: 40 beats 3.
    cfg(3, 1, 0, 1);
    cfg(40, 1, 0, 2);
    irq[3] = 1; irq[40] = 1;
    idle(3);
    ackPulse();
    idle(3);
    ackPulse();
    drain();

    // Equal level: lower index first.
    cfg(7, 1, 0, 2);
    cfg(9, 1, 0, 2);
    irq[7] = 1; irq[9] = 1;
    idle(3);
    ackPulse();
    idle(2);
    ackPulse();
    drain();

    // Masked pending request is offered after unmask.
    cfg(12, 1, 1, 0);
    irq[12] = 1;
    idle(20);
    cfg(12, 1, 0, 0);
    idle(3);
    ackPulse();
    drain();

    // No preemption of an outstanding offer; held level does not re-trigger.
    cfg(20, 1, 0, 0);
    cfg(2, 1, 0, 3);
    irq[20] = 1;
    idle(3);
    irq[2] = 1;
    idle(4);
    ackPulse();
    idle(3);
    ackPulse();
    idle(10);
    drain();

    // New edge coinciding with ack keeps the entry pending; reset mid-offer.
    cfg(4, 1, 0, 1);
    irq[4] = 1;
    idle(2);
    irq[4] = 0;
    idle(1);
    irq[4] = 1; ack = 1;
    tick();
    ack = 0;
    idle(3);
    rst = 1;
    tick();
    rst = 0;
    irq[4] = 0;
    idle(2);
    irq[4] = 1;
    idle(10);
    drain();

    // Randomized traffic over a pool of entries.
    for (int i = 0; i < 16; i++) cfg(i * 4, 1, $urandom_range(0, 3) == 0, $urandom_range(0, 3));
    for (int c = 0; c < 3000; c++) begin
      rst    = ($urandom_range(0, 499) == 0);
      ack    = ($urandom_range(0, 9) < 4);
      cfgReq = ($urandom_range(0, 9) == 0);
      cfgEnt = 6'($urandom_range(0, 15) * 4);
      cfgV   = ($urandom_range(0, 3) != 0);
      cfgM   = ($urandom_range(0, 9) < 3);
      cfgL   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) irq[$urandom_range(0, 15) * 4] ^= 1'b1;
      if ($urandom_range(0, 3) == 0) irq[$urandom_range(0, 63)] ^= 1'b1;
      tick();
    end
    rst = 0; cfgReq = 0; ack = 0;
    drain();
    @(negedge iCLOCK);

    tests++;
    if (expQ.size() != 0) begin
      fails++;
      $display("FAIL leftover got=%0d pending offers want=0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
